// File: rtl/eeg_filter_pkg.sv
// eeg_filter_pkg: width and limit helpers shared by the EEG filter.
// Optional: EEG_FILT_SAT_CNT_EN adds a saturation counter to the top.
package eeg_filter_pkg;

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(int dw, int wl);
    return dw + wl;
  endfunction

  function automatic logic [63:0] sat_max(int dw);
    return (64'd1 << dw) - 64'd1;
  endfunction

endpackage

// File: rtl/eeg_ch_window.sv
// eeg_ch_window: one channel's history, write pointer and running sum.
// sum_nx is the post-update sum, valid in the same cycle as wr_en.
module eeg_ch_window
  import eeg_filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 2,
  localparam int SW      = sum_w(DATA_W, WIN_LOG2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic [SW-1:0]     sum_nx
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int PW    = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;

  logic [DATA_W-1:0] hist_q [DEPTH];
  logic [DATA_W-1:0] hist_d [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0] old;

  always_comb begin
    old = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == PW'(i)) old = hist_q[i];
    end
    // oldest sample is always part of sum_q, so this never underflows
    sum_nx = sum_q - SW'(old) + SW'(din);
    hist_d = hist_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    if (wr_en) begin
      sum_d = sum_nx;
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr_q == PW'(i)) hist_d[i] = din;
      end
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      hist_q <= hist_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
    end
  end

endmodule

// File: rtl/eeg_channel_filter.sv
// eeg_channel_filter: per-channel moving average + offset with saturation.
// Optional: EEG_FILT_SAT_CNT_EN adds the sat_count output.
module eeg_channel_filter
  import eeg_filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int WIN_LOG2 = 2,
  parameter int OFFSET   = 1,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]   s_ch,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              m_sat,
`ifdef EEG_FILT_SAT_CNT_EN
  output logic [15:0]       sat_count,
`endif
  output logic              err_ch
);

  localparam int SW = sum_w(DATA_W, WIN_LOG2);
  localparam logic [DATA_W:0] SAT_V =
    (DATA_W + 1)'(sat_max(DATA_W));

  logic [NUM_CH-1:0] wr_en;
  logic [SW-1:0]     sum_nx [NUM_CH];
  logic [SW-1:0]     sel;
  logic [DATA_W-1:0] avg;
  logic [DATA_W:0]   res;
  logic              acc, ch_ok, sat;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]   m_ch_q, m_ch_d;
  logic              m_sat_q, m_sat_d;
  logic              err_ch_q, err_ch_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    eeg_ch_window #(
      .DATA_W   (DATA_W),
      .WIN_LOG2 (WIN_LOG2)
    ) u_win (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en[c]),
      .din    (s_data),
      .sum_nx (sum_nx[c])
    );
  end

  assign s_ready = !rst && (!m_valid_q || m_ready);

  always_comb begin
    acc   = s_valid && s_ready;
    ch_ok = {1'b0, s_ch} < (CH_W + 1)'(NUM_CH);
    wr_en = '0;
    sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_ch == CH_W'(c)) begin
        wr_en[c] = acc && ch_ok;
        sel      = sum_nx[c];
      end
    end
    avg = DATA_W'(sel >> WIN_LOG2);
    res = {1'b0, avg} + (DATA_W + 1)'(OFFSET);
    sat = res > SAT_V;

    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_ch_d    = m_ch_q;
    m_sat_d   = m_sat_q;
    err_ch_d  = acc && !ch_ok;
    if (acc && ch_ok) begin
      m_valid_d = 1'b1;
      m_data_d  = sat ? '1 : res[DATA_W-1:0];
      m_ch_d    = s_ch;
      m_sat_d   = sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
      m_sat_q   <= 1'b0;
      err_ch_q  <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
      m_sat_q   <= m_sat_d;
      err_ch_q  <= err_ch_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;
  assign m_sat   = m_sat_q;
  assign err_ch  = err_ch_q;

`ifdef EEG_FILT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (m_valid_q && m_ready && m_sat_q && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_eeg_channel_filter.sv
// tb_eeg_channel_filter: directed vectors for the EEG channel filter.
// Optional: EEG_FILT_SAT_CNT_EN also checks sat_count.
module tb_eeg_channel_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, m_valid, m_ready, m_sat, err_ch;
  logic [7:0] s_data, m_data;
  logic [1:0] s_ch, m_ch;
  logic       s3_valid, s3_ready, m3_valid, m3_sat, err3;
  logic [7:0] s3_data, m3_data;
  logic [1:0] s3_ch, m3_ch;
`ifdef EEG_FILT_SAT_CNT_EN
  logic [15:0] sat_count, sat3_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eeg_channel_filter #(
    .DATA_W(8), .NUM_CH(4), .WIN_LOG2(2), .OFFSET(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_ch(s_ch),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_sat(m_sat),
`ifdef EEG_FILT_SAT_CNT_EN
    .sat_count(sat_count),
`endif
    .err_ch(err_ch)
  );

  eeg_channel_filter #(
    .DATA_W(8), .NUM_CH(3), .WIN_LOG2(2), .OFFSET(1)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .s_valid(s3_valid), .s_ready(s3_ready),
    .s_data(s3_data), .s_ch(s3_ch),
    .m_valid(m3_valid), .m_ready(1'b1),
    .m_data(m3_data), .m_ch(m3_ch), .m_sat(m3_sat),
`ifdef EEG_FILT_SAT_CNT_EN
    .sat_count(sat3_count),
`endif
    .err_ch(err3)
  );

  typedef struct {
    logic [1:0] ch;
    logic [7:0] din;
    logic [7:0] ed;
    logic       es;
  } vec_t;

  vec_t vec [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // ch0 ramp, ch0 saturation, interleaved ch1/ch2, ch3 warm-up
    vec[0]  = '{2'd0, 8'd4,   8'd2,   1'b0};
    vec[1]  = '{2'd0, 8'd4,   8'd3,   1'b0};
    vec[2]  = '{2'd0, 8'd4,   8'd4,   1'b0};
    vec[3]  = '{2'd0, 8'd4,   8'd5,   1'b0};
    vec[4]  = '{2'd0, 8'd255, 8'd67,  1'b0};
    vec[5]  = '{2'd0, 8'd255, 8'd130, 1'b0};
    vec[6]  = '{2'd0, 8'd255, 8'd193, 1'b0};
    vec[7]  = '{2'd0, 8'd255, 8'd255, 1'b1};
    vec[8]  = '{2'd1, 8'd8,   8'd3,   1'b0};
    vec[9]  = '{2'd2, 8'd16,  8'd5,   1'b0};
    vec[10] = '{2'd1, 8'd8,   8'd5,   1'b0};
    vec[11] = '{2'd3, 8'd3,   8'd1,   1'b0};
    vec[12] = '{2'd3, 8'd200, 8'd51,  1'b0};

    rst = 1'b1;
    s_valid = 0; s_data = 0; s_ch = 0; m_ready = 1;
    s3_valid = 0; s3_data = 0; s3_ch = 0;
    step();
    step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_ch", m_ch, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_err_ch", err_ch, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);

    for (int i = 0; i < 13; i++) begin
      s_valid = 1'b1;
      s_ch    = vec[i].ch;
      s_data  = vec[i].din;
      #1;
      chk($sformatf("v%0d_s_ready", i), s_ready, 1);
      step();
      chk($sformatf("v%0d_m_valid", i), m_valid, 1);
      chk($sformatf("v%0d_m_data", i), m_data, vec[i].ed);
      chk($sformatf("v%0d_m_ch", i), m_ch, vec[i].ch);
      chk($sformatf("v%0d_m_sat", i), m_sat, vec[i].es);
      chk($sformatf("v%0d_err_ch", i), err_ch, 0);
    end
`ifdef EEG_FILT_SAT_CNT_EN
    chk("sat_count", sat_count, 1);
`endif
    s_valid = 1'b0;
    step();
    chk("drain_m_valid", m_valid, 0);

    // backpressure: ch0 history is 255 x4, sum 1020
    s_valid = 1'b1; s_ch = 2'd0; s_data = 8'd0;
    step();
    chk("bp_first", m_data, 192);
    m_ready = 1'b0;
    s_data  = 8'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_s_ready", i), s_ready, 0);
      step();
      chk($sformatf("bp%0d_m_valid", i), m_valid, 1);
      chk($sformatf("bp%0d_m_data", i), m_data, 192);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_release_s_ready", s_ready, 1);
    step();
    chk("bp_next_m_valid", m_valid, 1);
    chk("bp_next_m_data", m_data, 128);
    s_valid = 1'b0;
    step();
    chk("bp_drain", m_valid, 0);

    // invalid channel on the 3-channel instance
    s3_valid = 1'b1; s3_ch = 2'd3; s3_data = 8'd99;
    #1;
    chk("inv_s_ready", s3_ready, 1);
    step();
    chk("inv_m_valid", m3_valid, 0);
    chk("inv_err", err3, 1);
    s3_ch = 2'd0; s3_data = 8'd4;
    step();
    chk("inv_err_clr", err3, 0);
    chk("inv_next_valid", m3_valid, 1);
    chk("inv_next_data", m3_data, 2);
    chk("inv_next_ch", m3_ch, 0);
    s3_valid = 1'b0;
    step();
    chk("inv_err_idle", err3, 0);

    // mid-stream reset: ch2 (history 16,0,0,0) gets 40,40 then reset
    s_valid = 1'b1; s_ch = 2'd2; s_data = 8'd40;
    step();
    chk("mr_a", m_data, 15);
    step();
    chk("mr_b", m_data, 25);
    rst = 1'b1;
    s_valid = 1'b0;
    step();
    chk("mr_rst_m_valid", m_valid, 0);
    chk("mr_rst_s_ready", s_ready, 0);
    chk("mr_rst_m_data", m_data, 0);
`ifdef EEG_FILT_SAT_CNT_EN
    chk("mr_rst_sat_count", sat_count, 0);
`endif
    rst = 1'b0;
    #1;
    chk("mr_s_ready", s_ready, 1);
    s_valid = 1'b1; s_ch = 2'd2; s_data = 8'd4;
    step();
    chk("mr_after_valid", m_valid, 1);
    chk("mr_after_data", m_data, 2);
    s_valid = 1'b0; s_ch = 2'd0; s_data = 8'd4;
    s_valid = 1'b1;
    step();
    chk("mr_ch0_data", m_data, 2);
    s_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
